// File: rtl/bpsk_symbol_tx.sv
// -----------------------------------------------------------------------------
// bpsk_symbol_tx
//
// Test-pattern BPSK transmitter feeding the Gardner timing-recovery loopback.
// A free-running 32-bit phase accumulator advances by i_symbol_FTW every clk.
// Its carry-out is the symbol strobe. On each strobe the frame FSM emits one
// NRZ sample: an alternating preamble (+AMP first), then the data bytes
// MSB-first (1 -> +AMP, 0 -> -AMP). A single 0 sample closes the frame when
// no further byte is waiting at a byte boundary.
//
// Ports:
//   clk           system clock (only clock)
//   rst           asynchronous reset, active low
//   i_symbol_FTW  phase step per clk; symbol rate = f_clk * FTW / 2^32
//   i_byte        data byte offered upstream
//   i_byte_valid  i_byte is valid; accepted when valid && o_byte_ready
//   o_byte_ready  holding register empty (registered)
//   o_data        signed baseband sample, held for one symbol
//   o_sym_stb     one-clk pulse coincident with every o_data update
//   o_busy        high while a frame is in progress
// -----------------------------------------------------------------------------
module bpsk_symbol_tx #(
    parameter int                 PREAMBLE_LEN = 32,
    parameter logic signed [15:0] AMP          = 16'sd16384
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_symbol_FTW,
    input  logic [7:0]  i_byte,
    input  logic        i_byte_valid,
    output logic        o_byte_ready,
    output logic [15:0] o_data,
    output logic        o_sym_stb,
    output logic        o_busy
);

    // Counter wide enough to hold the value PREAMBLE_LEN itself.
    localparam int              PW         = $clog2(PREAMBLE_LEN + 1);
    localparam logic [PW-1:0]   PRE_LEN_C  = PW'(PREAMBLE_LEN);
    localparam logic [PW-1:0]   PRE_ONE_C  = PW'(1);
    localparam logic [PW-1:0]   PRE_ZERO_C = PW'(0);
    localparam logic [15:0]     POS_AMP_C  = 16'(AMP);
    // Two's complement of AMP at 16 bits.
    localparam logic [15:0]     NEG_AMP_C  = (~POS_AMP_C) + 16'd1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_DATA     = 2'd2
    } state_t;

    state_t         r_state;
    logic [31:0]    r_acc;
    logic [PW-1:0]  r_pre_cnt;
    logic [3:0]     r_bit_idx;
    logic [7:0]     r_shift;
    logic [7:0]     r_hold;
    logic           r_hold_full;
    logic           r_byte_ready;
    logic [15:0]    r_data;
    logic           r_sym_stb;
    logic           r_busy;

    logic [32:0]    w_sum;
    logic           w_carry;
    logic           w_accept;
    logic           w_at_boundary;
    logic           w_load;
    logic           w_hold_full_next;

    // NCO adder; bit 32 is the carry that marks a symbol boundary.
    assign w_sum    = {1'b0, r_acc} + {1'b0, i_symbol_FTW};
    assign w_carry  = w_sum[32];
    assign w_accept = i_byte_valid & r_byte_ready;

    // Byte-boundary detection, shift-register load and next holding state.
    always_comb begin
        w_at_boundary    = 1'b0;
        w_load           = 1'b0;
        w_hold_full_next = r_hold_full;
        case (r_state)
            ST_PREAMBLE: begin
                if (r_pre_cnt == PRE_LEN_C) begin
                    w_at_boundary = 1'b1;
                end else begin
                    w_at_boundary = 1'b0;
                end
            end
            ST_DATA: begin
                if (r_bit_idx == 4'd8) begin
                    w_at_boundary = 1'b1;
                end else begin
                    w_at_boundary = 1'b0;
                end
            end
            default: begin
                w_at_boundary = 1'b0;
            end
        endcase
        w_load = w_carry & w_at_boundary & r_hold_full;
        // Accept and load never coincide: ready is low whenever holding is full.
        if (w_accept) begin
            w_hold_full_next = 1'b1;
        end else if (w_load) begin
            w_hold_full_next = 1'b0;
        end else begin
            w_hold_full_next = r_hold_full;
        end
    end

    // NCO, byte handshake, frame FSM and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc        <= 32'd0;
            r_state      <= ST_IDLE;
            r_pre_cnt    <= PRE_ZERO_C;
            r_bit_idx    <= 4'd0;
            r_shift      <= 8'd0;
            r_hold       <= 8'd0;
            r_hold_full  <= 1'b0;
            r_byte_ready <= 1'b0;
            r_data       <= 16'd0;
            r_sym_stb    <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_acc        <= w_sum[31:0];
            r_sym_stb    <= w_carry;
            r_hold_full  <= w_hold_full_next;
            // Ready tracks the post-edge holding state so it drops on the
            // same edge that captures a byte.
            r_byte_ready <= ~w_hold_full_next;
            if (w_accept) begin
                r_hold <= i_byte;
            end else begin
                r_hold <= r_hold;
            end

            if (w_carry) begin
                if (w_at_boundary) begin
                    if (r_hold_full) begin
                        r_shift   <= r_hold;
                        r_data    <= r_hold[7] ? POS_AMP_C : NEG_AMP_C;
                        r_bit_idx <= 4'd1;
                        r_pre_cnt <= PRE_ZERO_C;
                        r_state   <= ST_DATA;
                        r_busy    <= 1'b1;
                    end else begin
                        // End of frame: one zero sample, then idle.
                        r_data    <= 16'd0;
                        r_bit_idx <= 4'd0;
                        r_pre_cnt <= PRE_ZERO_C;
                        r_state   <= ST_IDLE;
                        r_busy    <= 1'b0;
                    end
                end else begin
                    case (r_state)
                        ST_IDLE: begin
                            if (r_hold_full) begin
                                r_data    <= POS_AMP_C;
                                r_pre_cnt <= PRE_ONE_C;
                                r_bit_idx <= 4'd0;
                                r_state   <= ST_PREAMBLE;
                                r_busy    <= 1'b1;
                            end else begin
                                r_data    <= 16'd0;
                                r_busy    <= 1'b0;
                            end
                        end
                        ST_PREAMBLE: begin
                            // Even count -> +AMP, odd count -> -AMP.
                            r_data    <= r_pre_cnt[0] ? NEG_AMP_C : POS_AMP_C;
                            r_pre_cnt <= r_pre_cnt + PRE_ONE_C;
                        end
                        ST_DATA: begin
                            r_data    <= r_shift[3'd7 - r_bit_idx[2:0]] ? POS_AMP_C : NEG_AMP_C;
                            r_bit_idx <= r_bit_idx + 4'd1;
                        end
                        default: begin
                            r_data    <= 16'd0;
                            r_pre_cnt <= PRE_ZERO_C;
                            r_bit_idx <= 4'd0;
                            r_state   <= ST_IDLE;
                            r_busy    <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    assign o_byte_ready = r_byte_ready;
    assign o_data       = r_data;
    assign o_sym_stb    = r_sym_stb;
    assign o_busy       = r_busy;

endmodule

// File: doc/bpsk_symbol_tx.md
Name: bpsk_symbol_tx

Overview:
Test-pattern BPSK transmitter that produces the baseband stream our Gardner timing-recovery receiver locks onto. Accepts bytes over a valid/ready handshake and derives a symbol strobe from a 32-bit phase accumulator driven by a frequency tuning word. Emits an alternating-symbol preamble, then serialises the data MSB-first as NRZ ±AMP 16-bit signed samples. Sits on the DAC side of the loopback path, in the system clock domain.

Parameters:
PREAMBLE_LEN, 32, number of alternating preamble symbols per frame; legal values are even and ≥2.
AMP, 16384, signed 16-bit magnitude for symbol amplitude: bit 1 → +AMP, bit 0 → −AMP.

Ports:
clk  in  1  system clock; the only clock.
rst  in  1  asynchronous, active-low reset.
i_symbol_FTW  in  32  phase step per clk. Symbol rate = f_clk·FTW/2^32.
i_byte  in  8  data byte to transmit.
i_byte_valid  in  1  i_byte is valid.
o_byte_ready  out  1  holding register is empty; the byte is accepted when valid && ready.
o_data  out  16  signed baseband sample; held for one symbol.
o_sym_stb  out  1  one-clk pulse, coincident with each o_data update.
o_busy  out  1  high while state ≠ IDLE.

Behaviour:
- Reset (rst=0, asynchronous): phase accumulator=0; o_data=0; o_sym_stb=0; state=IDLE; holding register empty; shift register and counters=0; o_byte_ready=0. o_byte_ready rises on the first clk edge after release.
- NCO: acc <= acc + i_symbol_FTW every clk, free-running in all states, modulo 2^32.
- Symbol strobe: the carry-out of that add is registered into o_sym_stb. FTW=0 yields no strobes, and the FSM freezes.
- An FTW change takes effect on the next add. The accumulator is not reset on an FTW change.
- Handshake: 1-entry holding register. o_byte_ready is registered and equals !holding_full.
  - On valid && ready, capture i_byte and set holding_full.
  - Holding is freed only when a byte is loaded into the shift register. ready returns high the clk after the load.
  - The upstream source has 8 symbol periods to supply the next byte for gapless output.
- FSM transitions occur only on carry cycles. o_data and o_sym_stb are updated in the same registered cycle.
  - IDLE: o_data=0.
    - On carry with holding_full: go to PREAMBLE, emit +AMP, pre_cnt=1.
    - On carry with holding empty: stay in IDLE.
  - PREAMBLE, while pre_cnt<PREAMBLE_LEN: emit +AMP if pre_cnt is even, else −AMP; pre_cnt++.
  - PREAMBLE, when pre_cnt==PREAMBLE_LEN: do the byte boundary step.
  - DATA, while bit_idx<8: emit bit[7−bit_idx] mapped to ±AMP; bit_idx++.
  - DATA, when bit_idx==8: do the byte boundary step.
  - Byte boundary step:
    - If holding_full: load the shift register, free holding, emit bit7, set bit_idx=1, state=DATA.
    - Otherwise: emit 0, state=IDLE. This is the end of frame; the next frame restarts with a preamble.
- o_busy is registered: 1 in PREAMBLE and DATA, 0 in IDLE. It drops in the same cycle as the final o_data=0 strobe.
- Byte accepted while busy and mid-byte: it waits in holding, and the frame continues with no gap and no new preamble.
- Simultaneous accept and load cannot occur, because ready=0 while holding is full.
- Reset mid-frame: all state is cleared immediately. Holding and shift contents are discarded, o_data=0 asynchronously, and there is no partial-byte completion.
- Arithmetic: −AMP is formed as the two's complement of AMP at 16 bits. AMP=−32768 is illegal.

Test Plan:
- Strobe timing: reset release, FTW=32'h4000_0000 → first o_sym_stb on the 4th clk after release, then every 4 clks. Change FTW to 32'h8000_0000 mid-run → strobes every 2 clks with no missed or extra pulse.
- Single frame: PREAMBLE_LEN=4, AMP=16384, push 8'hA5 once. Expected o_data at successive strobes:
  - Preamble: +16384, −16384, +16384, −16384.
  - Data: +16384, −16384, +16384, −16384, −16384, +16384, −16384, +16384.
  - Then 0 with o_busy falling in that same cycle.
- Back-to-back: push 8'hFF then 8'h00, the second byte presented while the first is shifting → 4 preamble symbols, 8×+16384, 8×−16384, then 0. The second byte's ready drops for exactly one byte period, and there is no second preamble.
- Underflow gap: push 8'h80, then the next byte 3 symbols after the frame ends → two separate frames, each with its full preamble. o_data=0 between frames.
- FTW=0 with a byte pending → no strobe, o_busy stays 0, ready stays 0 after capture, o_data=0.
- Reset mid-frame: assert rst during data bit 3 → o_data, o_sym_stb and o_busy go to 0 immediately. After release, ready=1 on the first edge and a new byte starts a fresh preamble.
